hex_scan_driver: RTL and testbench

//  Upstream feeder for the 4-bit hex-to-7-segment decoder. Holds an N-digit hex value,

---
 rtl/hex_disp_pkg.sv | 26 ++
 rtl/edge_sync.sv | 28 ++
 rtl/hex_scan_driver.sv | 89 ++++++++
 tb/tb_hex_scan_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multiplexed hex display path.
// Digit width, default scan divider and the digit-enable encoder.
package hex_disp_pkg;

    localparam int DIGIT_W       = 4;
    localparam int MAX_DIGITS    = 16;
    localparam int SCAN_DIV_DFLT = 1000;
    localparam int PRESC_W_DFLT  = $clog2(SCAN_DIV_DFLT);

    // Bits at or above n stay 0 so callers may truncate to n bits.
    function automatic logic [MAX_DIGITS-1:0] onehot(
        input int idx,
        input int n,
        input bit act_low
    );
        logic [MAX_DIGITS-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                oh[i] = act_low ? (i != idx) : (i == idx);
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a single-cycle rising-edge pulse.
// Flops reset high so a button held through reset gives no pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/hex_scan_driver.sv
// Hex value register with button increment, scanned one nibble
// at a time onto a shared 7-segment decoder with digit enables.
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int SEL_ACT_LOW = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    input  logic                          clr,
    input  logic                          inc,
    output logic [DIGIT_W*NUM_DIGITS-1:0] value,
    output logic                          carry,
    output logic [DIGIT_W-1:0]            nibble,
    output logic [NUM_DIGITS-1:0]         digit_sel
);

    localparam int VW = DIGIT_W * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam bit ACT_LOW = (SEL_ACT_LOW != 0);

    logic          pulse;
    logic [VW-1:0] value_next;
    logic          carry_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic          tc;

    logic [MAX_DIGITS-1:0] sel_full;
    logic [MAX_DIGITS-1:0] sel_rst;

    edge_sync u_inc_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (inc),
        .rise (pulse)
    );

    always_comb begin
        value_next = value;
        carry_next = 1'b0;
        priority case (1'b1)
            clr:     value_next = '0;
            load:    value_next = load_data;
            pulse:   {carry_next, value_next} = {1'b0, value} + 1'b1;
            default: value_next = value;
        endcase
    end

    always_comb begin
        tc         = (presc == PW'(SCAN_DIV - 1));
        presc_next = tc ? '0 : presc + 1'b1;
        idx_next   = idx;
        if (tc) begin
            idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Outputs are built from the next-state values so nibble and
    // digit_sel move together with the value and scan index.
    assign sel_full = onehot(int'(idx_next), NUM_DIGITS, ACT_LOW);
    assign sel_rst  = onehot(0, NUM_DIGITS, ACT_LOW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value     <= '0;
            carry     <= 1'b0;
            presc     <= '0;
            idx       <= '0;
            nibble    <= '0;
            digit_sel <= NUM_DIGITS'(sel_rst);
        end else begin
            value     <= value_next;
            carry     <= carry_next;
            presc     <= presc_next;
            idx       <= idx_next;
            nibble    <= value_next[DIGIT_W*idx_next +: DIGIT_W];
            digit_sel <= NUM_DIGITS'(sel_full);
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with N=4, SCAN_DIV=4.
// Per-edge expectations are queued when driven and checked after the edge.
module tb_hex_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] load_data;
    logic        clr;
    logic        inc;
    logic [15:0] value;
    logic        carry;
    logic [3:0]  nibble;
    logic [3:0]  digit_sel;

    typedef struct {
        logic [3:0]  sel;
        logic [3:0]  nib;
        logic [15:0] val;
        logic        cy;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    logic [15:0] ev = '0;
    logic        ec = 1'b0;

    hex_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .SEL_ACT_LOW(0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .clr      (clr),
        .inc      (inc),
        .value    (value),
        .carry    (carry),
        .nibble   (nibble),
        .digit_sel(digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    // Queue what the next edge must produce, take the edge, then compare.
    task automatic tick();
        int          kn;
        int          ix;
        logic [3:0]  s;
        exp_t        e;
        exp_t        got;
        kn = rst_n ? k + 1 : 0;
        ix = (kn / 4) % 4;
        s  = 4'b0001;
        e.sel = s << ix;
        e.nib = ev[4*ix +: 4];
        e.val = ev;
        e.cy  = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        k = kn;
        got = sb.pop_front();
        check("digit_sel", {12'h0, digit_sel}, {12'h0, got.sel});
        check("nibble", {12'h0, nibble}, {12'h0, got.nib});
        check("value", value, got.val);
        check("carry", {15'h0, carry}, {15'h0, got.cy});
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        load_data = '0;
        clr = 1'b0;
        inc = 1'b0;

        // reset then idle scan
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) tick();

        // parallel load, watch one full scan
        load = 1'b1;
        load_data = 16'hA3C5;
        ev = 16'hA3C5;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) tick();

        // held button gives a single increment with carry across digits
        load = 1'b1;
        load_data = 16'h00FF;
        ev = 16'h00FF;
        tick();
        load = 1'b0;
        inc = 1'b1;
        tick();
        tick();
        ev = 16'h0100;
        tick();
        for (int i = 0; i < 7; i++) tick();
        inc = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // wrap from all-F raises carry for one cycle
        load = 1'b1;
        load_data = 16'hFFFF;
        ev = 16'hFFFF;
        tick();
        load = 1'b0;
        inc = 1'b1;
        tick();
        tick();
        ev = 16'h0000;
        ec = 1'b1;
        tick();
        ec = 1'b0;
        inc = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // clr beats load and pulse on the same edge
        load = 1'b1;
        load_data = 16'hFFFF;
        ev = 16'hFFFF;
        tick();
        load = 1'b0;
        inc = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        load = 1'b1;
        load_data = 16'h1234;
        ev = 16'h0000;
        tick();
        clr = 1'b0;
        load = 1'b0;
        inc = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // load beats pulse on the same edge
        inc = 1'b1;
        tick();
        tick();
        load = 1'b1;
        load_data = 16'h1234;
        ev = 16'h1234;
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // button held through reset release: no increment
        rst_n = 1'b0;
        ev = 16'h0000;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // reset mid-scan at digit 2
        load = 1'b1;
        load_data = 16'hBEEF;
        ev = 16'hBEEF;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16 && ((k / 4) % 4) != 2; i++) tick();
        check("scan_idx", 16'(((k / 4) % 4)), 16'd2);
        rst_n = 1'b0;
        ev = 16'h0000;
        tick();
        rst_n = 1'b1;
        inc = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
